// File: rtl/redmule_mx_slot_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : redmule_mx_slot_arbiter
//  Description : Arbitrates between the X and W MX slot streams and feeds
//                one beat per cycle into a single decoder output register.
//                X exponents are replicated across the W exponent vector.
//                Ties between streams alternate.
//  Revision    : 1.0 - initial release
// ============================================================================
module redmule_mx_slot_arbiter #(
    parameter int unsigned MX_DATA_W       = 256,
    parameter int unsigned MX_EXP_VECTOR_W = 32,
    parameter int unsigned CNT_W           = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       clear_i,
    input  logic                       mx_enable_i,
    input  logic                       start_i,
    input  logic [CNT_W-1:0]           x_total_i,
    input  logic [CNT_W-1:0]           w_total_i,
    input  logic                       x_slot_valid_i,
    input  logic [MX_DATA_W-1:0]       x_slot_data_i,
    input  logic [7:0]                 x_slot_exp_i,
    output logic                       consume_x_slot_o,
    input  logic                       w_slot_valid_i,
    input  logic [MX_DATA_W-1:0]       w_slot_data_i,
    input  logic [MX_EXP_VECTOR_W-1:0] w_slot_exp_i,
    output logic                       consume_w_slot_o,
    output logic                       dec_valid_o,
    input  logic                       dec_ready_i,
    output logic [MX_DATA_W-1:0]       dec_data_o,
    output logic [MX_EXP_VECTOR_W-1:0] dec_exp_o,
    output logic                       dec_is_w_o,
    output logic                       busy_o,
    output logic                       done_o
);

    localparam int unsigned EXP_REP = MX_EXP_VECTOR_W / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   x_total_q, w_total_q;
    logic [CNT_W-1:0]   x_cnt_q, w_cnt_q;
    logic [CNT_W-1:0]   x_cnt_next, w_cnt_next;
    logic               last_grant_w_q;   // 1 = W was granted last
    logic               reg_free;
    logic               x_req, w_req;
    logic               grant_x, grant_w;

    // Request qualification and round-robin grant between the two streams
    always_comb begin
        reg_free   = !dec_valid_o || dec_ready_i;
        x_req      = (state_q == RUN) && mx_enable_i && x_slot_valid_i && (x_cnt_q < x_total_q);
        w_req      = (state_q == RUN) && mx_enable_i && w_slot_valid_i && (w_cnt_q < w_total_q);
        grant_x    = !clear_i && reg_free && x_req && (!w_req || last_grant_w_q);
        grant_w    = !clear_i && reg_free && w_req && (!x_req || !last_grant_w_q);
        x_cnt_next = x_cnt_q + CNT_W'(grant_x);
        w_cnt_next = w_cnt_q + CNT_W'(grant_w);
    end

    assign consume_x_slot_o = grant_x;
    assign consume_w_slot_o = grant_w;
    assign busy_o           = (state_q != IDLE);
    assign done_o           = (state_q == DONE);

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; completion is judged on the post-grant counts
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = RUN;
            RUN:     if ((x_cnt_next == x_total_q) && (w_cnt_next == w_total_q)) state_d = DRAIN;
            DRAIN:   if (!dec_valid_o) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (clear_i) state_d = IDLE;
    end

    // Job totals, issue counters and tie-break history
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            x_total_q      <= '0;
            w_total_q      <= '0;
            x_cnt_q        <= '0;
            w_cnt_q        <= '0;
            last_grant_w_q <= 1'b1;
        end else if (clear_i) begin
            x_total_q      <= '0;
            w_total_q      <= '0;
            x_cnt_q        <= '0;
            w_cnt_q        <= '0;
            last_grant_w_q <= 1'b1;
        end else if ((state_q == IDLE) && start_i) begin
            x_total_q <= x_total_i;
            w_total_q <= w_total_i;
            x_cnt_q   <= '0;
            w_cnt_q   <= '0;
        end else begin
            x_cnt_q <= x_cnt_next;
            w_cnt_q <= w_cnt_next;
            if (grant_x) last_grant_w_q <= 1'b0;
            if (grant_w) last_grant_w_q <= 1'b1;
        end
    end

    // Decoder output register: load on grant, drop valid when consumed
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dec_valid_o <= 1'b0;
            dec_data_o  <= '0;
            dec_exp_o   <= '0;
            dec_is_w_o  <= 1'b0;
        end else if (clear_i) begin
            dec_valid_o <= 1'b0;
        end else if (grant_x) begin
            dec_valid_o <= 1'b1;
            dec_data_o  <= x_slot_data_i;
            dec_exp_o   <= {EXP_REP{x_slot_exp_i}};
            dec_is_w_o  <= 1'b0;
        end else if (grant_w) begin
            dec_valid_o <= 1'b1;
            dec_data_o  <= w_slot_data_i;
            dec_exp_o   <= w_slot_exp_i;
            dec_is_w_o  <= 1'b1;
        end else if (dec_valid_o && dec_ready_i) begin
            dec_valid_o <= 1'b0;
        end
    end

endmodule
`default_nettype wire
